// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: walks the datapath through IF/ID/EXE/MEM/WB,
// decodes every datapath control from state/opcode/funct/zero and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [2:0]       state,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             ir_wr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic             alu_src_b,
  output logic             ext_sel,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             isR;
  logic             rAluValid;
  logic [2:0]       rAluOp;

  assign isR = (opcode == OP_RTYPE);

  always_comb begin
    rAluValid = 1'b1;
    rAluOp    = 3'b000;
    unique case (funct)
      6'b100000: rAluOp = 3'b000;
      6'b100010: rAluOp = 3'b001;
      6'b100100: rAluOp = 3'b010;
      6'b100101: rAluOp = 3'b011;
      6'b101010: rAluOp = 3'b100;
      default:   rAluValid = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    pc_wr     = 1'b0;
    pc_src    = 2'b00;
    ir_wr     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    reg_wr    = 1'b0;
    reg_dst   = 2'b00;
    wb_src    = 2'b00;
    alu_src_b = 1'b0;
    ext_sel   = 1'b0;
    alu_op    = 3'b000;
    halted    = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      S_IF: begin
        mem_rd  = 1'b1;
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (isR && funct == FN_JR) begin
          pc_wr   = 1'b1;
          pc_src  = 2'b11;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (isR && rAluValid) begin
          state_d = S_EXE;
        end else begin
          unique case (opcode)
            OP_J: begin
              pc_wr   = 1'b1;
              pc_src  = 2'b10;
              retire  = 1'b1;
              state_d = S_IF;
            end
            OP_JAL: begin
              pc_wr   = 1'b1;
              pc_src  = 2'b10;
              reg_wr  = 1'b1;
              reg_dst = 2'b00;
              wb_src  = 2'b10;
              retire  = 1'b1;
              state_d = S_IF;
            end
            OP_HALT: begin
              retire  = 1'b1;
              state_d = S_HALT;
            end
            OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_d = S_EXE;
            default: begin
              // Undecodable instructions (including bad R funct) fall through as a nop.
              illegal = 1'b1;
              state_d = S_IF;
            end
          endcase
        end
      end
      S_EXE: begin
        state_d = S_IF;
        if (isR) begin
          alu_op  = rAluOp;
          state_d = S_WB;
        end else begin
          unique case (opcode)
            OP_ADDI: begin
              alu_src_b = 1'b1;
              ext_sel   = 1'b1;
              state_d   = S_WB;
            end
            OP_ORI: begin
              alu_src_b = 1'b1;
              alu_op    = 3'b011;
              state_d   = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_src_b = 1'b1;
              ext_sel   = 1'b1;
              state_d   = S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              alu_op  = 3'b001;
              ext_sel = 1'b1;
              pc_src  = 2'b01;
              pc_wr   = (opcode == OP_BEQ) ? zero : ~zero;
              retire  = 1'b1;
            end
            default: state_d = S_IF;
          endcase
        end
      end
      S_MEM: begin
        state_d = S_IF;
        if (opcode == OP_LW) begin
          mem_rd  = 1'b1;
          state_d = S_WB;
        end else if (opcode == OP_SW) begin
          mem_wr = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        reg_dst = isR ? 2'b10 : 2'b01;
        wb_src  = (opcode == OP_LW) ? 2'b01 : 2'b00;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IF;
    endcase

    // Reset must silence every strobe immediately, not just at the next edge.
    if (rst) begin
      retire    = 1'b0;
      pc_wr     = 1'b0;
      pc_src    = 2'b00;
      ir_wr     = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      reg_wr    = 1'b0;
      reg_dst   = 2'b00;
      wb_src    = 2'b00;
      alu_src_b = 1'b0;
      ext_sel   = 1'b0;
      alu_op    = 3'b000;
      halted    = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle MIPS control unit; sequences the datapath through IF/ID/EXE/MEM/WB.
- Drives the register-destination select (00=$31, 01=rt, 10=rd), the ALU, memory, PC and write-back controls.
- Also counts retired instructions.
- Sits between the instruction register (opcode/funct) and all datapath muxes and write enables.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26]; stable from ID onward
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag, valid in EXE
- state  output  3  current state encoding
- pc_wr  output  1  PC write enable
- pc_src  output  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
- ir_wr  output  1  IR write enable
- mem_rd  output  1  memory read
- mem_wr  output  1  memory write
- reg_wr  output  1  register file write enable
- reg_dst  output  2  00 $31, 01 rt, 10 rd, 11 unused (never driven)
- wb_src  output  2  00 ALU result, 01 memory data, 10 PC+4
- alu_src_b  output  1  0 rt register, 1 extended immediate
- ext_sel  output  1  0 zero-extend, 1 sign-extend
- alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- halted  output  1  high in HALT state
- illegal  output  1  one-cycle pulse in ID on an undecodable instruction
- instr_cnt  output  CNT_W  retired-instruction count

Behaviour:
- States: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111. The state register resets asynchronously to IF.
- While rst=1, every output is 0, including instr_cnt and state strobes.
- All outputs except instr_cnt and state are combinational decodes of state, opcode, funct and zero.
- Undriven controls are 0.
- Decode:
  - R-type: opcode 000000 with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 001000 jr.
  - Immediate: addi 001000, ori 001101.
  - Memory: lw 100011, sw 101011.
  - Branch/jump: beq 000100, bne 000101, j 000010, jal 000011, halt 111111.
- IF: mem_rd=1, ir_wr=1, pc_wr=1, pc_src=00; next state ID.
- ID:
  - j: pc_wr=1, pc_src=10; retire; next IF.
  - jr: pc_wr=1, pc_src=11; retire; next IF.
  - jal: pc_wr=1, pc_src=10, reg_wr=1, reg_dst=00, wb_src=10; retire; next IF.
  - halt: retire; next HALT.
  - Illegal opcode or R funct: illegal=1, no writes, no retire; next IF (treated as nop).
  - All other instructions: next EXE.
- EXE:
  - R-type: alu_src_b=0, alu_op from funct; next WB.
  - addi: alu_src_b=1, ext_sel=1, alu_op=000; next WB.
  - ori: alu_src_b=1, ext_sel=0, alu_op=011; next WB.
  - lw/sw: alu_src_b=1, ext_sel=1, alu_op=000; next MEM.
  - beq/bne: alu_src_b=0, alu_op=001, ext_sel=1.
    - pc_wr=zero for beq, pc_wr=~zero for bne; pc_src=01.
    - Retire; next IF.
- MEM:
  - lw: mem_rd=1; next WB.
  - sw: mem_wr=1; retire; next IF.
- WB: reg_wr=1; retire; next IF.
  - R-type: reg_dst=10, wb_src=00.
  - addi/ori: reg_dst=01, wb_src=00.
  - lw: reg_dst=01, wb_src=01.
- HALT: all strobes 0, halted=1; remains in HALT until rst.
- Latency in cycles: j/jr/jal/halt 2, beq/bne 3, R/addi/ori/sw 4, lw 5.
- instr_cnt:
  - Increments by 1 on the clock edge ending each retiring cycle.
  - Wraps from all-ones to 0.
  - Never increments in HALT or on illegal instructions.
- Reset mid-instruction: state returns to IF and instr_cnt to 0 immediately, with no edge needed. No partial write strobes are asserted while rst=1.

Test Plan:
- Reset, then add (000000/100000), 4 cycles:
  - states 000→001→010→100→000.
  - WB cycle: reg_wr=1, reg_dst=10, wb_src=00.
  - alu_op=000 in EXE; instr_cnt=1.
- lw then sw:
  - lw takes 5 cycles: mem_rd=1 in MEM, WB reg_dst=01, wb_src=01.
  - sw takes 4 cycles: mem_wr=1 in MEM, no reg_wr.
  - instr_cnt=2.
- beq with zero=1: pc_wr=1, pc_src=01 in EXE. beq with zero=0: pc_wr=0. bne with zero=0: pc_wr=1. Each is 3 cycles.
- jal in ID: pc_wr=1, pc_src=10, reg_wr=1, reg_dst=00, wb_src=10; next state IF after 2 cycles.
- Opcode 010000: illegal=1 for one ID cycle, no writes, instr_cnt unchanged. Then halt: halted=1 and state=111 held for 20 cycles.
- Assert rst during the lw MEM cycle: all outputs 0 and instr_cnt=0 asynchronously. After release, the first cycle is IF.
